// File: rtl/row_burst_scheduler.sv
// Two-requester round-robin row burst scheduler with a latency-matched response tag pipeline.
// Optional strobe/row_valid consistency checker enabled by ROW_BURST_SCHEDULER_CHECK_EN.
module row_burst_scheduler #(
    parameter int NUM_ROWS       = 3,
    parameter int MEMORY_LATENCY = 2,
    localparam int ROW_ADDR_WIDTH = $clog2(NUM_ROWS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0_valid,
    input  logic [ROW_ADDR_WIDTH-1:0] req0_start,
    input  logic [ROW_ADDR_WIDTH-1:0] req0_len,
    output logic                      req0_ready,
    input  logic                      req1_valid,
    input  logic [ROW_ADDR_WIDTH-1:0] req1_start,
    input  logic [ROW_ADDR_WIDTH-1:0] req1_len,
    output logic                      req1_ready,
    output logic [ROW_ADDR_WIDTH-1:0] row_addr,
    output logic                      row_addr_ready,
    output logic                      resp0_valid,
    output logic                      resp1_valid,
    output logic                      resp0_last,
    output logic                      resp1_last,
`ifdef ROW_BURST_SCHEDULER_CHECK_EN
    input  logic                      row_valid,
    output logic                      sched_err,
`endif
    output logic                      busy
);

    localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW = ROW_ADDR_WIDTH'(NUM_ROWS - 1);

    typedef enum logic {StIdle, StBurst} state_t;

    state_t                    state_q;
    logic [ROW_ADDR_WIDTH-1:0] row_addr_q;
    logic [ROW_ADDR_WIDTH-1:0] remain_q;
    logic                      owner_q;
    logic                      ptr_q;

    logic                      arb_en;
    logic                      grant0;
    logic                      grant1;
    logic [ROW_ADDR_WIDTH-1:0] win_start;
    logic [ROW_ADDR_WIDTH-1:0] win_len;
    logic [ROW_ADDR_WIDTH-1:0] win_len_clamped;
    logic [ROW_ADDR_WIDTH-1:0] next_addr;

    logic [MEMORY_LATENCY-1:0] tag_strobe_q;
    logic [MEMORY_LATENCY-1:0] tag_owner_q;
    logic [MEMORY_LATENCY-1:0] tag_last_q;

    // Arbitrate when idle or while issuing the final address, giving back-to-back bursts.
    always_comb begin
        arb_en          = (state_q == StIdle) || (remain_q == '0);
        grant0          = !rst && arb_en && req0_valid && (!req1_valid || !ptr_q);
        grant1          = !rst && arb_en && req1_valid && (!req0_valid || ptr_q);
        win_start       = grant1 ? req1_start : req0_start;
        win_len         = grant1 ? req1_len : req0_len;
        win_len_clamped = (win_len > LAST_ROW) ? LAST_ROW : win_len;
        next_addr       = (row_addr_q == LAST_ROW) ? '0 : row_addr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            row_addr_q <= '0;
            remain_q   <= '0;
            owner_q    <= 1'b0;
            ptr_q      <= 1'b0;
        end else if (grant0 || grant1) begin
            state_q    <= StBurst;
            row_addr_q <= win_start;
            remain_q   <= win_len_clamped;
            owner_q    <= grant1;
            ptr_q      <= grant0;
        end else if (state_q == StBurst) begin
            if (remain_q == '0) begin
                state_q <= StIdle;
            end else begin
                row_addr_q <= next_addr;
                remain_q   <= remain_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_strobe_q <= '0;
            tag_owner_q  <= '0;
            tag_last_q   <= '0;
        end else begin
            tag_strobe_q[0] <= (state_q == StBurst);
            tag_owner_q[0]  <= owner_q;
            tag_last_q[0]   <= (remain_q == '0);
            for (int i = 1; i < MEMORY_LATENCY; i++) begin
                tag_strobe_q[i] <= tag_strobe_q[i-1];
                tag_owner_q[i]  <= tag_owner_q[i-1];
                tag_last_q[i]   <= tag_last_q[i-1];
            end
        end
    end

`ifdef ROW_BURST_SCHEDULER_CHECK_EN
    // Sticky: any cycle where the matrix disagrees with the expected read return.
    always_ff @(posedge clk) begin
        if (rst) begin
            sched_err <= 1'b0;
        end else if (row_valid != tag_strobe_q[MEMORY_LATENCY-1]) begin
            sched_err <= 1'b1;
        end
    end
`endif

    assign req0_ready     = grant0;
    assign req1_ready     = grant1;
    assign row_addr       = row_addr_q;
    assign row_addr_ready = (state_q == StBurst);
    assign resp0_valid    = tag_strobe_q[MEMORY_LATENCY-1] && !tag_owner_q[MEMORY_LATENCY-1];
    assign resp1_valid    = tag_strobe_q[MEMORY_LATENCY-1] && tag_owner_q[MEMORY_LATENCY-1];
    assign resp0_last     = resp0_valid && tag_last_q[MEMORY_LATENCY-1];
    assign resp1_last     = resp1_valid && tag_last_q[MEMORY_LATENCY-1];
    assign busy           = (state_q == StBurst) || (|tag_strobe_q);

endmodule

// File: tb/tb_row_burst_scheduler.sv
// Self-checking bench: directed scenarios then random traffic against a schedule-queue model.
module tb_row_burst_scheduler;

    localparam int NR  = 8;
    localparam int LAT = 2;
    localparam int AW  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_start, req0_len, req1_start, req1_len;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] row_addr;
    logic          row_addr_ready;
    logic          resp0_valid, resp1_valid, resp0_last, resp1_last;
    logic          busy;
`ifdef ROW_BURST_SCHEDULER_CHECK_EN
    logic          row_valid;
    logic          sched_err;
`endif

    always #5 clk = ~clk;

    row_burst_scheduler #(
        .NUM_ROWS      (NR),
        .MEMORY_LATENCY(LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req0_valid    (req0_valid),
        .req0_start    (req0_start),
        .req0_len      (req0_len),
        .req0_ready    (req0_ready),
        .req1_valid    (req1_valid),
        .req1_start    (req1_start),
        .req1_len      (req1_len),
        .req1_ready    (req1_ready),
        .row_addr      (row_addr),
        .row_addr_ready(row_addr_ready),
        .resp0_valid   (resp0_valid),
        .resp1_valid   (resp1_valid),
        .resp0_last    (resp0_last),
        .resp1_last    (resp1_last),
`ifdef ROW_BURST_SCHEDULER_CHECK_EN
        .row_valid     (row_valid),
        .sched_err     (sched_err),
`endif
        .busy          (busy)
    );

    // Model: queue of reads still to be issued (front = this cycle) and a history of issued reads.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic          owner;
        logic          last;
    } issue_t;

    issue_t sched[$];
    logic   hist_s[LAT];
    logic   hist_o[LAT];
    logic   hist_l[LAT];
    logic   m_ptr;
    bit     rand_mode;
    int     checks;
    int     fails;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        sched.delete();
        for (int i = 0; i < LAT; i++) begin
            hist_s[i] = 1'b0;
            hist_o[i] = 1'b0;
            hist_l[i] = 1'b0;
        end
        m_ptr = 1'b0;
    endtask

    task automatic cycle();
        logic          g0, g1, s_now, any_hist, w;
        logic [AW-1:0] st, ln;
        int            n;
        @(negedge clk);
        g0    = !rst && sched.size() <= 1 && req0_valid && (!req1_valid || !m_ptr);
        g1    = !rst && sched.size() <= 1 && req1_valid && (!req0_valid || m_ptr);
        s_now = sched.size() > 0;
        any_hist = 1'b0;
        for (int i = 0; i < LAT; i++) any_hist |= hist_s[i];
        chk("req0_ready", 8'(req0_ready), 8'(g0));
        chk("req1_ready", 8'(req1_ready), 8'(g1));
        chk("row_addr_ready", 8'(row_addr_ready), 8'(s_now));
        if (s_now) chk("row_addr", 8'(row_addr), 8'(sched[0].addr));
        chk("resp0_valid", 8'(resp0_valid), 8'(hist_s[LAT-1] && !hist_o[LAT-1]));
        chk("resp1_valid", 8'(resp1_valid), 8'(hist_s[LAT-1] && hist_o[LAT-1]));
        chk("resp0_last", 8'(resp0_last), 8'(hist_s[LAT-1] && !hist_o[LAT-1] && hist_l[LAT-1]));
        chk("resp1_last", 8'(resp1_last), 8'(hist_s[LAT-1] && hist_o[LAT-1] && hist_l[LAT-1]));
        chk("busy", 8'(busy), 8'(s_now || any_hist));
`ifdef ROW_BURST_SCHEDULER_CHECK_EN
        chk("sched_err", 8'(sched_err), 8'h0);
`endif
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                hist_s[i] = hist_s[i-1];
                hist_o[i] = hist_o[i-1];
                hist_l[i] = hist_l[i-1];
            end
            hist_s[0] = s_now;
            hist_o[0] = s_now ? sched[0].owner : 1'b0;
            hist_l[0] = s_now ? sched[0].last : 1'b0;
            if (s_now) void'(sched.pop_front());
            if (g0 || g1) begin
                w  = g1;
                st = g1 ? req1_start : req0_start;
                ln = g1 ? req1_len : req0_len;
                n  = ((int'(ln) < NR - 1) ? int'(ln) : NR - 1) + 1;
                for (int i = 0; i < n; i++)
                    sched.push_back('{AW'((int'(st) + i) % NR), w, (i == n - 1)});
                m_ptr = g0;
            end
        end
        #1;
        if (g0) req0_valid = 1'b0;
        if (g1) req1_valid = 1'b0;
`ifdef ROW_BURST_SCHEDULER_CHECK_EN
        row_valid = hist_s[LAT-1];
`endif
        if (rand_mode) begin
            if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1'b1;
                req0_start = AW'($urandom);
                req0_len   = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 1)) : AW'($urandom);
            end
            if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1'b1;
                req1_start = AW'($urandom);
                req1_len   = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 1)) : AW'($urandom);
            end
            rst = ($urandom_range(0, 79) == 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        fails = 0;
        rand_mode = 1'b0;
        model_clear();
        rst = 1'b1;
        req0_valid = 1'b0; req0_start = '0; req0_len = '0;
        req1_valid = 1'b0; req1_start = '0; req1_len = '0;
`ifdef ROW_BURST_SCHEDULER_CHECK_EN
        row_valid = 1'b0;
`endif
        cycle();
        do_reset();
        chk("reset_row_addr", 8'(row_addr), 8'h0);

        // Basic burst: start 2, four rows.
        req0_valid = 1'b1; req0_start = 3'd2; req0_len = 3'd3;
        repeat (8) cycle();

        // Wrap from row 7 to row 0.
        req0_valid = 1'b1; req0_start = 3'd6; req0_len = 3'd3;
        repeat (8) cycle();

        // Simultaneous single-row requests after reset: req0 first, req1 with no bubble.
        do_reset();
        req0_valid = 1'b1; req0_start = 3'd1; req0_len = 3'd0;
        req1_valid = 1'b1; req1_start = 3'd5; req1_len = 3'd0;
        repeat (6) cycle();

        // Full-length burst aborted by reset on its third strobe.
        req1_valid = 1'b1; req1_start = 3'd0; req1_len = 3'd7;
        repeat (3) cycle();
        do_reset();
        repeat (4) cycle();
        chk("busy_after_abort", 8'(busy), 8'h0);

        // Full burst followed by a waiting requester granted on the last address.
        req0_valid = 1'b1; req0_start = 3'd4; req0_len = 3'd7;
        cycle();
        req1_valid = 1'b1; req1_start = 3'd3; req1_len = 3'd2;
        repeat (14) cycle();

        rand_mode = 1'b1;
        repeat (1500) cycle();
        rand_mode = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        repeat (12) cycle();
        do_reset();
        cycle();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
